// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: state encoding, register-index width, control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    // x0 is hard-wired to zero, so a load targeting it never creates a dependency
    localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

    // Sequencer states, 2-bit legacy encoding
    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_LD_STALL  = 2'd1;
    localparam logic [1:0] ST_BR_PEND   = 2'd2;
    localparam logic [1:0] ST_DMEM_WAIT = 2'd3;

    // Per-cycle pipeline register controls
    typedef struct packed {
        logic pc_hold;
        logic reg1_hold;
        logic reg2_hold;
        logic reg3_hold;
        logic reg1_bubble;
        logic reg2_bubble;
        logic reg4_bubble;
    } ctrl_t;

endpackage

// File: rtl/hazard_match.sv
// Load-use detector: flags an ID source register that matches the destination of a valid load in EX.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is consumed by the hazard sequencer.
module hazard_match
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_memRead,
    input  logic                  ex_Insthit,
    output logic                  ld_use
);

    logic rs1_hit;
    logic rs2_hit;

    // Compare each used ID source against the EX load destination, ignoring x0
    always_comb begin
        rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
        rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
        ld_use  = ex_Insthit && ex_memRead && (ex_rd != REG_X0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline registers; perf counters built only with HAZARD_PERF_EN.
// Latency: hold/bubble controls are combinational from state and hazard inputs; state advances on clock.
// Backpressure: dmem/imem busywait hold the pipeline; no handshake on this block itself.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int LD_BUBBLES = 1,
    parameter int CNT_W      = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_memRead,
    input  logic                  ex_Insthit,
    input  logic                  ex_redirect,
    input  logic                  imem_busywait,
    input  logic                  dmem_busywait,
    output logic                  pc_hold,
    output logic                  reg1_hold,
    output logic                  reg2_hold,
    output logic                  reg3_hold,
    output logic                  reg1_bubble,
    output logic                  reg2_bubble,
    output logic                  reg4_bubble,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    // Bubble counter only needs to hold LD_BUBBLES-1
    localparam int                BCNT_W  = (LD_BUBBLES > 1) ? $clog2(LD_BUBBLES) : 1;
    localparam logic [BCNT_W-1:0] LD_INIT = BCNT_W'(LD_BUBBLES - 1);

    logic [1:0]        state_q, state_d;
    logic [1:0]        eff_state;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic              redir_pend_q, redir_pend_d;
    logic              ld_use;
    ctrl_t             ctrl;

    hazard_match u_match (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_rd      (ex_rd),
        .ex_memRead (ex_memRead),
        .ex_Insthit (ex_Insthit),
        .ld_use     (ld_use)
    );

    // Prioritised hazard resolution: dmem wait, then redirect, then load-use, then fetch wait.
    // DMEM_WAIT with the wait released behaves exactly as RUN, so it shares RUN's decode.
    // A dmem wait arriving in LD_STALL/BR_PEND freezes that sequence until the wait clears.
    always_comb begin
        ctrl         = '0;
        state_d      = state_q;
        bcnt_d       = bcnt_q;
        redir_pend_d = redir_pend_q;
        eff_state    = (state_q == ST_DMEM_WAIT) ? ST_RUN : state_q;

        if (dmem_busywait) begin
            ctrl.pc_hold     = 1'b1;
            ctrl.reg1_hold   = 1'b1;
            ctrl.reg2_hold   = 1'b1;
            ctrl.reg3_hold   = 1'b1;
            ctrl.reg4_bubble = 1'b1;
            if (eff_state == ST_RUN) begin
                state_d = ST_DMEM_WAIT;
            end
        end else if (redir_pend_q) begin
            // Keep squashing the stale fetch until it lands
            ctrl.reg1_bubble = 1'b1;
            if (!imem_busywait) begin
                redir_pend_d = 1'b0;
                state_d      = ST_RUN;
            end
        end else if (ex_redirect) begin
            // Flush wins over any load-use: the dependent ID instruction is discarded
            ctrl.reg1_bubble = 1'b1;
            ctrl.reg2_bubble = 1'b1;
            if (imem_busywait) begin
                redir_pend_d = 1'b1;
                state_d      = ST_BR_PEND;
            end else begin
                state_d      = ST_RUN;
            end
        end else if ((eff_state == ST_LD_STALL) || ld_use) begin
            ctrl.pc_hold     = 1'b1;
            ctrl.reg1_hold   = 1'b1;
            ctrl.reg2_bubble = 1'b1;
            if (eff_state == ST_LD_STALL) begin
                if (bcnt_q == BCNT_W'(1)) begin
                    state_d = ST_RUN;
                end else begin
                    bcnt_d  = bcnt_q - BCNT_W'(1);
                end
            end else if (LD_BUBBLES > 1) begin
                bcnt_d  = LD_INIT;
                state_d = ST_LD_STALL;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            if (imem_busywait) begin
                ctrl.pc_hold     = 1'b1;
                ctrl.reg1_bubble = 1'b1;
            end
            state_d = ST_RUN;
        end
    end

    // Sequencer state registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            bcnt_q       <= '0;
            redir_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bcnt_q       <= bcnt_d;
            redir_pend_q <= redir_pend_d;
        end
    end

    // Outputs forced low while reset is held so nothing leaks from the pre-reset state
    assign pc_hold     = reset & ctrl.pc_hold;
    assign reg1_hold   = reset & ctrl.reg1_hold;
    assign reg2_hold   = reset & ctrl.reg2_hold;
    assign reg3_hold   = reset & ctrl.reg3_hold;
    assign reg1_bubble = reset & ctrl.reg1_bubble;
    assign reg2_bubble = reset & ctrl.reg2_bubble;
    assign reg4_bubble = reset & ctrl.reg4_bubble;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic             redir_acc;

    // A redirect is accepted when nothing above it in priority claims the cycle
    assign redir_acc = ex_redirect & ~dmem_busywait & ~redir_pend_q;

    // Saturating stall and flush event counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (pc_hold && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (redir_acc && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (1 and 2 load bubbles) driven in parallel.
// Latency: checks combinational controls each cycle, counters one cycle after the event.
// Backpressure: busywait patterns are part of the stimulus.
module tb_pipeline_hazard_ctrl;

    localparam int TB_CW   = 4;
    localparam int CNT_MAX = (1 << TB_CW) - 1;
`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_memRead, ex_Insthit;
    logic       ex_redirect, imem_busywait, dmem_busywait;

    logic [1:0] pc_hold, reg1_hold, reg2_hold, reg3_hold;
    logic [1:0] reg1_bubble, reg2_bubble, reg4_bubble;
    logic [TB_CW-1:0] stall_cnt [2];
    logic [TB_CW-1:0] flush_cnt [2];

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: owed load bubbles, pending fetch squash, event counts
    int m_ld_left [2];
    bit m_rp      [2];
    int m_sc      [2];
    int m_fc      [2];

    always #5 clock = ~clock;

    pipeline_hazard_ctrl #(.LD_BUBBLES(1), .CNT_W(TB_CW)) dut0 (
        .clock(clock), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_memRead(ex_memRead), .ex_Insthit(ex_Insthit),
        .ex_redirect(ex_redirect), .imem_busywait(imem_busywait), .dmem_busywait(dmem_busywait),
        .pc_hold(pc_hold[0]), .reg1_hold(reg1_hold[0]), .reg2_hold(reg2_hold[0]),
        .reg3_hold(reg3_hold[0]), .reg1_bubble(reg1_bubble[0]), .reg2_bubble(reg2_bubble[0]),
        .reg4_bubble(reg4_bubble[0]), .stall_cnt(stall_cnt[0]), .flush_cnt(flush_cnt[0])
    );

    pipeline_hazard_ctrl #(.LD_BUBBLES(2), .CNT_W(TB_CW)) dut1 (
        .clock(clock), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_memRead(ex_memRead), .ex_Insthit(ex_Insthit),
        .ex_redirect(ex_redirect), .imem_busywait(imem_busywait), .dmem_busywait(dmem_busywait),
        .pc_hold(pc_hold[1]), .reg1_hold(reg1_hold[1]), .reg2_hold(reg2_hold[1]),
        .reg3_hold(reg3_hold[1]), .reg1_bubble(reg1_bubble[1]), .reg2_bubble(reg2_bubble[1]),
        .reg4_bubble(reg4_bubble[1]), .stall_cnt(stall_cnt[1]), .flush_cnt(flush_cnt[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Controls packed as {pc_hold, reg1_hold, reg2_hold, reg3_hold, reg1_bubble, reg2_bubble, reg4_bubble}
    function automatic logic [6:0] get_out(input int i);
        return {pc_hold[i], reg1_hold[i], reg2_hold[i], reg3_hold[i],
                reg1_bubble[i], reg2_bubble[i], reg4_bubble[i]};
    endfunction

    function automatic logic [31:0] exp_cnt(input int v);
        if (!reset || !PERF) return 32'd0;
        return v;
    endfunction

    // Expected controls for this cycle; advances the model to the next cycle
    task automatic model_step(input int i, output logic [6:0] o);
        bit ldu;
        int lb;
        lb = (i == 0) ? 1 : 2;
        o  = 7'b0;
        if (!reset) begin
            m_ld_left[i] = 0;
            m_rp[i]      = 1'b0;
            m_sc[i]      = 0;
            m_fc[i]      = 0;
            return;
        end
        ldu = ex_Insthit && ex_memRead && (ex_rd != 5'd0) &&
              ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (dmem_busywait) begin
            o = 7'b1111001;
        end else if (m_rp[i]) begin
            o = 7'b0000100;
            if (!imem_busywait) m_rp[i] = 1'b0;
        end else if (ex_redirect) begin
            o            = 7'b0000110;
            m_ld_left[i] = 0;
            m_rp[i]      = imem_busywait;
            if (m_fc[i] < CNT_MAX) m_fc[i]++;
        end else if (m_ld_left[i] > 0 || ldu) begin
            o = 7'b1100010;
            if (m_ld_left[i] > 0) m_ld_left[i]--;
            else                  m_ld_left[i] = lb - 1;
        end else if (imem_busywait) begin
            o = 7'b1000100;
        end
        if (o[6] && m_sc[i] < CNT_MAX) m_sc[i]++;
    endtask

    // Compare both instances against the model with the current inputs
    task automatic cyc();
        logic [6:0] e;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("stall_cnt%0d", i), 32'(stall_cnt[i]), exp_cnt(m_sc[i]));
            chk($sformatf("flush_cnt%0d", i), 32'(flush_cnt[i]), exp_cnt(m_fc[i]));
            model_step(i, e);
            chk($sformatf("ctrl%0d", i), 32'(get_out(i)), 32'(e));
        end
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                          input logic [4:0] rd, input logic mr, input logic hit,
                          input logic redir, input logic ib, input logic db);
        @(negedge clock);
        id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        ex_rd = rd; ex_memRead = mr; ex_Insthit = hit;
        ex_redirect = redir; imem_busywait = ib; dmem_busywait = db;
    endtask

    task automatic idle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
    endtask

    initial begin
        reset = 1'b0;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("reset_ctrl0", 32'(get_out(0)), 32'd0);
        // Hazard inputs present during reset must not leak to the outputs
        id_rs1 = 5'd5; id_use_rs1 = 1'b1; ex_rd = 5'd5; ex_memRead = 1'b1; ex_Insthit = 1'b1;
        dmem_busywait = 1'b1;
        cyc();
        chk("reset_ctrl_masked", 32'(get_out(1)), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        idle();

        // lw x5 in EX, add x6,x5,x7 in ID; the 2-bubble instance is then reset inside LD_STALL
        set_in(5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("ld1_stall", 32'(get_out(0)), 32'b1100010);
        chk("ld2_stall_a", 32'(get_out(1)), 32'b1100010);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("ld2_stall_b", 32'(get_out(1)), 32'b1100010);
        reset = 1'b0;
        cyc();
        chk("rst_in_ldstall", 32'(get_out(1)), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        cyc();
        chk("run_after_rst", 32'(get_out(1)), 32'd0);

        // Single load-use: exactly one stall cycle with one load bubble
        set_in(5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("t1_stall", 32'(get_out(0)), 32'b1100010);
        idle();
        chk("t1_once", 32'(get_out(0)), 32'd0);

        // Redirect with 3 cycles of fetch wait
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc();
        chk("br_c1", 32'(get_out(0)), 32'b0000110);
        for (int k = 2; k <= 3; k++) begin
            set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            cyc();
            chk($sformatf("br_c%0d", k), 32'(get_out(0)), 32'b0000100);
        end
        idle();
        chk("br_c4", 32'(get_out(0)), 32'b0000100);
        idle();
        chk("br_c5", 32'(get_out(0)), 32'd0);
        chk("perf_stall", 32'(stall_cnt[0]), PERF ? 32'd1 : 32'd0);
        chk("perf_flush", 32'(flush_cnt[0]), PERF ? 32'd1 : 32'd0);

        // No-stall cases: rd = x0, and rs2-only match with rs2 unused; then rs2 used
        set_in(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("no_stall_x0", 32'(get_out(0)), 32'd0);
        set_in(5'd3, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("no_stall_rs2", 32'(get_out(0)), 32'd0);
        set_in(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("stall_rs2", 32'(get_out(0)), 32'b1100010);
        idle();

        // dmem wait over a redirect: 5 held cycles, flush on the 6th
        for (int k = 1; k <= 5; k++) begin
            set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            cyc();
            chk($sformatf("dm_c%0d", k), 32'(get_out(0)), 32'b1111001);
        end
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        chk("dm_c6_flush", 32'(get_out(0)), 32'b0000110);
        idle();
        chk("dm_c7", 32'(get_out(0)), 32'd0);

        // Saturation of both counters
        for (int k = 0; k < 20; k++) begin
            set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            cyc();
        end
        for (int k = 0; k < 20; k++) begin
            set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            cyc();
        end
        idle();
        chk("stall_sat", 32'(stall_cnt[0]), PERF ? 32'(CNT_MAX) : 32'd0);
        chk("flush_sat", 32'(flush_cnt[0]), PERF ? 32'(CNT_MAX) : 32'd0);

        // Randomised traffic against the model, with occasional resets
        for (int n = 0; n < 3000; n++) begin
            @(negedge clock);
            reset         = ($urandom_range(0, 199) != 0);
            id_rs1        = 5'($urandom_range(0, 3));
            id_rs2        = 5'($urandom_range(0, 3));
            id_use_rs1    = 1'($urandom_range(0, 1));
            id_use_rs2    = 1'($urandom_range(0, 1));
            ex_rd         = 5'($urandom_range(0, 3));
            ex_memRead    = 1'($urandom_range(0, 1));
            ex_Insthit    = ($urandom_range(0, 3) != 0);
            ex_redirect   = ($urandom_range(0, 7) == 0);
            imem_busywait = ($urandom_range(0, 3) == 0);
            dmem_busywait = ($urandom_range(0, 7) == 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
